// File: rtl/clksw_pkg.sv
// clksw_pkg: shared state encoding and source-select constants for the clock-switch sequencer.
package clksw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SWITCH,
        DONE,
        ERR
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/clksw_tog_sync.sv
// clksw_tog_sync: synchronizes an asynchronous divider toggle into clk and flags either-polarity edges.
module clksw_tog_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tog,
    output logic tog_edge
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tog};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign tog_edge = sync[SYNC_STAGES-1] ^ hist;

endmodule

// File: rtl/clksw_ctl.sv
// clksw_ctl: request/check/switch/settle sequencer owning the glitchless mux sel.
// Define CLKSW_ALIVE_CHK_EN to verify target-source activity before switching.
module clksw_ctl
    import clksw_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int ACT_WIN     = 64,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_req,
    input  logic sw_tgt,
    output logic sw_rdy,
    output logic sw_done,
    output logic sw_err,
    output logic sel,
    input  logic a_tog,
    input  logic b_tog
);

    if (SYNC_STAGES < 2 || (1 << CNT_W) < SETTLE_CYC || (1 << CNT_W) < ACT_WIN) begin : g_bad_cfg
        $error("clksw_ctl: SYNC_STAGES must be >= 2 and CNT_W must cover SETTLE_CYC and ACT_WIN");
    end

    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             sel_nx, done_nx;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign sw_rdy  = (state == IDLE);

`ifdef CLKSW_ALIVE_CHK_EN
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACT_WIN - 1);

    logic a_edge, b_edge, tgt_edge, tgt, tgt_nx, err_nx;

    clksw_tog_sync #(.SYNC_STAGES(SYNC_STAGES)) u_a_sync (
        .clk(clk), .rst(rst), .tog(a_tog), .tog_edge(a_edge)
    );

    clksw_tog_sync #(.SYNC_STAGES(SYNC_STAGES)) u_b_sync (
        .clk(clk), .rst(rst), .tog(b_tog), .tog_edge(b_edge)
    );

    // Only the requested source's activity matters; the other may be idle or gated.
    assign tgt_edge = (tgt == SRC_B) ? b_edge : a_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt    <= SRC_A;
            sw_err <= 1'b0;
        end else begin
            tgt    <= tgt_nx;
            sw_err <= err_nx;
        end
    end
`else
    logic unused_tog;

    assign unused_tog = a_tog ^ b_tog;
    assign sw_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= SRC_A;
            sw_done <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            sel     <= sel_nx;
            sw_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_inc;
        sel_nx   = sel;
        done_nx  = 1'b0;
`ifdef CLKSW_ALIVE_CHK_EN
        tgt_nx   = tgt;
        err_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (sw_req) begin
`ifdef CLKSW_ALIVE_CHK_EN
                    tgt_nx   = sw_tgt;
                    state_nx = (sw_tgt == sel) ? DONE : CHECK;
`else
                    state_nx = (sw_tgt == sel) ? DONE : SWITCH;
                    sel_nx   = sw_tgt;
`endif
                end
            end
`ifdef CLKSW_ALIVE_CHK_EN
            // An edge in the final window cycle still counts.
            CHECK: begin
                if (tgt_edge) begin
                    state_nx = SWITCH;
                    sel_nx   = tgt;
                    cnt_nx   = '0;
                end else if (cnt == ACT_END) begin
                    state_nx = ERR;
                end
            end
            ERR: begin
                err_nx   = 1'b1;
                state_nx = IDLE;
            end
`endif
            SWITCH: state_nx = (cnt == SETTLE_END) ? DONE : SWITCH;
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clksw_ctl.sv
// tb_clksw_ctl: scoreboard bench for clksw_ctl; expectations adapt to CLKSW_ALIVE_CHK_EN.
module tb_clksw_ctl;

    localparam int SETTLE = 16;
    localparam int WIN    = 64;
`ifdef CLKSW_ALIVE_CHK_EN
    localparam bit ALIVE = 1'b1;
`else
    localparam bit ALIVE = 1'b0;
`endif

    typedef struct {
        logic err;
        logic sel;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, sw_req, sw_tgt, a_tog, b_tog;
    logic sw_rdy, sw_done, sw_err, sel;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_sel;

    clksw_ctl #(
        .SYNC_STAGES(2), .SETTLE_CYC(SETTLE), .ACT_WIN(WIN), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .sw_req(sw_req), .sw_tgt(sw_tgt),
        .sw_rdy(sw_rdy), .sw_done(sw_done), .sw_err(sw_err), .sel(sel),
        .a_tog(a_tog), .b_tog(b_tog)
    );

    always #5 clk = ~clk;

    // Latency is measured from the edge that accepted the request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && sw_req && sw_rdy) acc_q.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1);
    end

    task automatic toggle(input logic src);
        if (src) b_tog = ~b_tog;
        else a_tog = ~a_tog;
    endtask

    task automatic issue(input logic tgt);
        sw_req = 1'b1;
        sw_tgt = tgt;
        @(posedge clk);
        #1 sw_req = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output logic [3:0] obs, output int lat);
        obs = 4'b0;
        lat = -1;
        for (int i = 0; i < budget && !obs[3]; i++) begin
            @(negedge clk);
            if (sw_done || sw_err) begin
                obs = {1'b1, sw_err, sw_done, sel};
                lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sw_req = 1'b0; sw_tgt = 1'b0; a_tog = 1'b0; b_tog = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sel, sw_rdy, sw_done, sw_err} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_state: {sel,rdy,done,err}=%b want 0100", {sel, sw_rdy, sw_done, sw_err});
        end
        exp_sel = 1'b0;
    endtask

    task automatic test_same_target;
        logic [3:0] obs;
        int         lat;
        exp_t       ex;
        exp_q.push_back('{err: 1'b0, sel: exp_sel, lat: 2});
        issue(exp_sel);
        @(negedge clk);
        n_cmp++;
        if ({sel, sw_rdy} !== {exp_sel, 1'b0}) begin
            n_bad++;
            $display("FAIL same_busy: {sel,rdy}=%b want %b", {sel, sw_rdy}, {exp_sel, 1'b0});
        end
        wait_pulse(20, obs, lat);
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, ex.err, !ex.err, ex.sel}) begin
            n_bad++;
            $display("FAIL same_pulse: {seen,err,done,sel}=%b want %b", obs, {1'b1, ex.err, !ex.err, ex.sel});
        end
        n_cmp++;
        if (lat !== ex.lat) begin
            n_bad++;
            $display("FAIL same_latency: %0d want %0d", lat, ex.lat);
        end
    endtask

    task automatic test_inactive;
        logic [3:0] obs;
        int         lat;
        exp_t       ex;
        logic       tgt;
        tgt = ~exp_sel;
        exp_q.push_back('{err: ALIVE, sel: ALIVE ? exp_sel : tgt, lat: ALIVE ? WIN + 2 : SETTLE + 2});
        issue(tgt);
        toggle(~tgt);
        @(negedge clk);
        n_cmp++;
        if (sel !== (ALIVE ? exp_sel : tgt)) begin
            n_bad++;
            $display("FAIL inactive_sel_c1: %b want %b", sel, ALIVE ? exp_sel : tgt);
        end
        wait_pulse(200, obs, lat);
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, ex.err, !ex.err, ex.sel}) begin
            n_bad++;
            $display("FAIL inactive_pulse: {seen,err,done,sel}=%b want %b", obs, {1'b1, ex.err, !ex.err, ex.sel});
        end
        n_cmp++;
        if (lat !== ex.lat) begin
            n_bad++;
            $display("FAIL inactive_latency: %0d want %0d", lat, ex.lat);
        end
        exp_sel = ex.sel;
    endtask

    task automatic test_last_window;
        logic [3:0] obs;
        int         lat;
        exp_t       ex;
        logic       tgt;
        tgt = ~exp_sel;
        exp_q.push_back('{err: 1'b0, sel: tgt, lat: (ALIVE ? WIN : 0) + 2 + SETTLE});
        issue(tgt);
        repeat (ALIVE ? WIN - 3 : 0) @(posedge clk);
        #1 toggle(tgt);
        @(negedge clk);
        n_cmp++;
        if (sel !== (ALIVE ? exp_sel : tgt)) begin
            n_bad++;
            $display("FAIL window_sel_pre: %b want %b", sel, ALIVE ? exp_sel : tgt);
        end
        wait_pulse(200, obs, lat);
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, ex.err, !ex.err, ex.sel}) begin
            n_bad++;
            $display("FAIL window_pulse: {seen,err,done,sel}=%b want %b", obs, {1'b1, ex.err, !ex.err, ex.sel});
        end
        n_cmp++;
        if (lat !== ex.lat) begin
            n_bad++;
            $display("FAIL window_latency: %0d want %0d", lat, ex.lat);
        end
        exp_sel = tgt;
    endtask

    task automatic test_switch;
        logic [3:0] obs;
        int         lat;
        exp_t       ex;
        logic       tgt;
        tgt = ~exp_sel;
        exp_q.push_back('{err: 1'b0, sel: tgt, lat: ALIVE ? 5 + SETTLE : 2 + SETTLE});
        issue(tgt);
        toggle(tgt);
        @(negedge clk);
        n_cmp++;
        if (sel !== (ALIVE ? exp_sel : tgt)) begin
            n_bad++;
            $display("FAIL switch_sel_c1: %b want %b", sel, ALIVE ? exp_sel : tgt);
        end
        repeat (3) @(posedge clk);
        #1 toggle(tgt);
        @(negedge clk);
        n_cmp++;
        if ({sel, sw_rdy} !== {tgt, 1'b0}) begin
            n_bad++;
            $display("FAIL switch_c4: {sel,rdy}=%b want %b", {sel, sw_rdy}, {tgt, 1'b0});
        end
        wait_pulse(200, obs, lat);
        ex = exp_q.pop_front();
        n_cmp++;
        if (obs !== {1'b1, ex.err, !ex.err, ex.sel}) begin
            n_bad++;
            $display("FAIL switch_pulse: {seen,err,done,sel}=%b want %b", obs, {1'b1, ex.err, !ex.err, ex.sel});
        end
        n_cmp++;
        if (lat !== ex.lat) begin
            n_bad++;
            $display("FAIL switch_latency: %0d want %0d", lat, ex.lat);
        end
        exp_sel = tgt;
    endtask

    task automatic test_back_to_back;
        logic [3:0] obs;
        int         lat;
        exp_t       ex;
        logic       t1, t2;
        t1 = ~exp_sel;
        t2 = exp_sel;
        exp_q.push_back('{err: 1'b0, sel: t1, lat: ALIVE ? 5 + SETTLE : 2 + SETTLE});
        exp_q.push_back('{err: 1'b0, sel: t2, lat: ALIVE ? 5 + SETTLE : 2 + SETTLE});
        sw_req = 1'b1;
        sw_tgt = t1;
        @(posedge clk);
        #1 sw_tgt = t2;
        toggle(t1);
        for (int k = 0; k < 2; k++) begin
            wait_pulse(200, obs, lat);
            ex = exp_q.pop_front();
            n_cmp++;
            if (obs !== {1'b1, ex.err, !ex.err, ex.sel}) begin
                n_bad++;
                $display("FAIL b2b_pulse%0d: {seen,err,done,sel}=%b want %b", k, obs, {1'b1, ex.err, !ex.err, ex.sel});
            end
            n_cmp++;
            if (lat !== ex.lat) begin
                n_bad++;
                $display("FAIL b2b_latency%0d: %0d want %0d", k, lat, ex.lat);
            end
            if (k == 0) begin
                @(posedge clk);
                #1 sw_req = 1'b0;
                toggle(t2);
            end
        end
        exp_sel = t2;
    endtask

    task automatic test_reset_mid;
        int pulses;
        if (exp_sel) test_switch();
        issue(1'b1);
        toggle(1'b1);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({sel, sw_rdy} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_pre: {sel,rdy}=%b want 10", {sel, sw_rdy});
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if (sel !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async_sel: %b want 0", sel);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        acc_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({sel, sw_rdy, sw_done, sw_err} !== 4'b0100) begin
            n_bad++;
            $display("FAIL rstmid_after: {sel,rdy,done,err}=%b want 0100", {sel, sw_rdy, sw_done, sw_err});
        end
        pulses = 0;
        repeat (2 * SETTLE + 10) begin
            @(negedge clk);
            if (sw_done || sw_err) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL rstmid_pulses: %0d want 0", pulses);
        end
        exp_sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_same_target();
        test_inactive();
        test_last_window();
        test_switch();
        test_back_to_back();
        test_reset_mid();
        test_same_target();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
